multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_W, default 6: opcode width.
REQ-002 Parameter ALU_OP_W, default 2, minimum 2: width of alu_op. Upper bits above [1:0] SHALL always be 0.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 instr_op  input  OP_W  opcode from the instruction register; sampled only in DECODE.
REQ-006 mem_ready  input  1  memory handshake; 1 = access completes this cycle.
REQ-007 Outputs, width 1 each: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-008 alu_src_b  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-009 pc_source  output  2  PC select: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-010 alu_op  output  ALU_OP_W  ALU operation: 00 = add, 01 = subtract, 10 = use funct field.
REQ-011 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 state  output  4  current state encoding, for debug.

Function
REQ-013 The block SHALL be a Moore FSM. Outputs decode from state, plus mem_ready where stated. Any output not listed for a state SHALL be 0.
REQ-014 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11. Codes 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-015 FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00. ir_write=1 and pc_write=1 only when mem_ready=1. Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-016 DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BRANCH
- 001000 -> IEXEC
- any other opcode -> FETCH, with illegal_op=1 during DECODE.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for 100011, MEMWR for 101011; opcode is held from DECODE.
REQ-018 MEMRD: mem_read=1, i_or_d=1. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-019 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
REQ-020 MEMWR: mem_write=1, i_or_d=1. Hold while mem_ready=0; go to FETCH when mem_ready=1.
REQ-021 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
REQ-022 RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
REQ-024 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Go to IWB.
REQ-025 IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
REQ-026 The opcode SHALL be latched in an internal register on leaving DECODE, so later states ignore changes on instr_op.
REQ-027 Cycle counts with mem_ready=1 throughout: R-type 4, lw 5, sw 4, beq 3, addi 4. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.

Reset
REQ-028 While rst=0, state SHALL be FETCH, the latched opcode SHALL be 0, and all outputs SHALL be forced to 0 regardless of clk.
REQ-029 On rst going from 0 to 1, FETCH outputs SHALL appear immediately. The first transition occurs on the first rising clk edge.
REQ-030 When rst falls during any access (FETCH, MEMRD or MEMWR), mem_read and mem_write SHALL drop to 0 at once. No partial write strobe SHALL be issued after rst=0.

Configuration
REQ-031 Macro MC_JUMP_EN defined: opcode 000010 in DECODE SHALL go to JUMP. JUMP asserts pc_write=1 and pc_source=10, then goes to FETCH (3 cycles total).
REQ-032 Macro MC_JUMP_EN undefined: the JUMP state SHALL not exist, and opcode 000010 SHALL be handled as illegal per REQ-016.

Verification
REQ-033 rst=0 for 3 cycles, then rst=1 with mem_ready=1 -> state=0, mem_read=1 and ir_write=1 in the first cycle after release; all outputs were 0 during reset.
REQ-034 lw (100011) with mem_ready=1 -> state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 in state 4 only.
REQ-035 sw (101011) with mem_ready low for 2 cycles in MEMWR -> state 5 for 3 cycles with mem_write=1, then state 0.
REQ-036 beq (000100) -> states 0,1,8,0; in state 8, pc_write_cond=1, alu_op=01, pc_source=01.
REQ-037 Opcode 111111 -> illegal_op=1 for exactly the one DECODE cycle, then state 0. Repeat with 000010: under MC_JUMP_EN -> states 0,1,11,0 with pc_write=1 and pc_source=10 in state 11; without the macro -> illegal_op=1.
REQ-038 rst=0 mid-MEMRD while mem_ready=0 -> outputs 0 asynchronously, before the next clk edge; after release, state=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM (Moore), asynchronous active-low reset.
// Optional JUMP state enabled by defining MC_JUMP_EN.
module multicycle_control #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     instr_op,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal_op,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10
`ifdef MC_JUMP_EN
        , JUMP = 4'd11
`endif
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
`ifdef MC_JUMP_EN
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`endif

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [1:0]      alu_op_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op_c      = 2'b00;
        illegal_op    = 1'b0;
        unique case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                op_d      = instr_op;
                if (instr_op == OP_RTYPE)                          state_d = EXEC;
                else if (instr_op == OP_LW || instr_op == OP_SW)   state_d = MEMADR;
                else if (instr_op == OP_BEQ)                       state_d = BRANCH;
                else if (instr_op == OP_ADDI)                      state_d = IEXEC;
`ifdef MC_JUMP_EN
                else if (instr_op == OP_J)                         state_d = JUMP;
`endif
                else begin
                    state_d    = FETCH;
                    illegal_op = 1'b1;
                end
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op_c  = 2'b10;
                state_d   = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op_c      = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = FETCH;
            end
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = IWB;
            end
            IWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
        // Reset masks every strobe combinationally so an access aborts without waiting for clk.
        if (!rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 2'b00;
            alu_op_c      = 2'b00;
            illegal_op    = 1'b0;
        end
    end

    assign alu_op = ALU_OP_W'(alu_op_c);
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; expected output words are hand-derived.
// Works with or without MC_JUMP_EN defined.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] instr_op = '0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source, alu_op;
    logic [3:0] state;
    logic [16:0] outs;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.OP_W(6), .ALU_OP_W(2)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,pc_source,alu_op,illegal_op}
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                   alu_op, illegal_op};

    localparam logic [16:0] E_ZERO   = 17'b0;
    localparam logic [16:0] E_FRDY   = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_FWAIT  = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_DEC    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_DECILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [16:0] E_MEMADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_MEMWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_EXEC   = {10'b0000000001, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [16:0] E_RWB    = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_BRANCH = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [16:0] E_IEXEC  = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_IWB    = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
`ifdef MC_JUMP_EN
    localparam logic [16:0] E_JUMP   = {10'b1000000000, 2'b00, 2'b10, 2'b00, 1'b0};
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] OP_J    = 6'b000010;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs, let combinational outputs settle, check, then advance to the next negedge.
    task automatic go(input logic mr, input logic [5:0] op, input logic [3:0] exp_st,
                      input logic [16:0] exp_outs, input string tag);
        mem_ready = mr;
        instr_op  = op;
        #1;
        chk({tag, ".state"}, {13'b0, state}, {13'b0, exp_st});
        chk({tag, ".outs"}, outs, exp_outs);
        @(negedge clk);
    endtask

    initial begin
        // reset held for 3 cycles with mem_ready high: everything must stay 0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst.state", {13'b0, state}, 17'd0);
            chk("rst.outs", outs, E_ZERO);
        end
        @(negedge clk);
        rst = 1'b1;

        // lw; instr_op is cleared in MEMADR to confirm the latched opcode steers to MEMRD
        go(1'b1, OP_LW, 4'd0, E_FRDY,   "lw.fetch");
        go(1'b1, OP_LW, 4'd1, E_DEC,    "lw.decode");
        go(1'b1, OP_R,  4'd2, E_MEMADR, "lw.memadr");
        go(1'b1, OP_R,  4'd3, E_MEMRD,  "lw.memrd");
        go(1'b1, OP_R,  4'd4, E_MEMWB,  "lw.memwb");

        // sw with two wait cycles in MEMWR
        go(1'b1, OP_SW, 4'd0, E_FRDY,   "sw.fetch");
        go(1'b1, OP_SW, 4'd1, E_DEC,    "sw.decode");
        go(1'b1, OP_SW, 4'd2, E_MEMADR, "sw.memadr");
        go(1'b0, OP_SW, 4'd5, E_MEMWR,  "sw.memwr0");
        go(1'b0, OP_SW, 4'd5, E_MEMWR,  "sw.memwr1");
        go(1'b1, OP_SW, 4'd5, E_MEMWR,  "sw.memwr2");

        // R-type with one fetch wait cycle
        go(1'b0, OP_R, 4'd0, E_FWAIT, "r.fetchwait");
        go(1'b1, OP_R, 4'd0, E_FRDY,  "r.fetch");
        go(1'b1, OP_R, 4'd1, E_DEC,   "r.decode");
        go(1'b1, OP_R, 4'd6, E_EXEC,  "r.exec");
        go(1'b1, OP_R, 4'd7, E_RWB,   "r.rwb");

        go(1'b1, OP_BEQ, 4'd0, E_FRDY,   "beq.fetch");
        go(1'b1, OP_BEQ, 4'd1, E_DEC,    "beq.decode");
        go(1'b1, OP_BEQ, 4'd8, E_BRANCH, "beq.branch");

        go(1'b1, OP_ADDI, 4'd0, E_FRDY,  "addi.fetch");
        go(1'b1, OP_ADDI, 4'd1, E_DEC,   "addi.decode");
        go(1'b1, OP_ADDI, 4'd9, E_IEXEC, "addi.iexec");
        go(1'b1, OP_ADDI, 4'd10, E_IWB,  "addi.iwb");

        // illegal opcode pulses for the single DECODE cycle
        go(1'b1, OP_BAD, 4'd0, E_FRDY,   "bad.fetch");
        go(1'b1, OP_BAD, 4'd1, E_DECILL, "bad.decode");

        go(1'b1, OP_J, 4'd0, E_FRDY, "j.fetch");
`ifdef MC_JUMP_EN
        go(1'b1, OP_J, 4'd1, E_DEC,   "j.decode");
        go(1'b1, OP_J, 4'd11, E_JUMP, "j.jump");
`else
        go(1'b1, OP_J, 4'd1, E_DECILL, "j.decode_illegal");
`endif

        // async reset during a stalled MEMRD
        go(1'b1, OP_LW, 4'd0, E_FRDY,   "ar.fetch");
        go(1'b1, OP_LW, 4'd1, E_DEC,    "ar.decode");
        go(1'b1, OP_LW, 4'd2, E_MEMADR, "ar.memadr");
        go(1'b0, OP_LW, 4'd3, E_MEMRD,  "ar.memrd");
        #1;
        chk("ar.stall.state", {13'b0, state}, 17'd3);
        rst = 1'b0;
        #1;
        chk("ar.async.state", {13'b0, state}, 17'd0);
        chk("ar.async.outs", outs, E_ZERO);
        @(negedge clk);
        #1;
        chk("ar.held.outs", outs, E_ZERO);
        @(negedge clk);
        rst = 1'b1;
        go(1'b1, OP_R, 4'd0, E_FRDY, "ar.release");
        go(1'b1, OP_R, 4'd1, E_DEC,  "ar.decode2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
